ritc_phase_shift_controller: RTL and testbench

// - Initiator for the RITC clock generator's dynamic phase-shift/reset interface; runs on phase_control_clk.
// - Turns one signed step command into a sequence of single PSEN pulses, each acknowledged by PSDONE.
// - Tracks the accumulated phase position and watchdogs PSDONE.
// - Issues the generator's MMCM reset (bit 7) as a held pulse.

---
 rtl/ritc_phase_shift_controller.sv | 180 ++++++++++++++++++
 tb/tb_ritc_phase_shift_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ritc_phase_shift_controller.sv
`timescale 1ns/1ps
// ritc_phase_shift_controller
// Initiator for the RITC clock generator's dynamic phase-shift / reset port.
// One signed step command is expanded into single PSEN pulses. Each pulse
// waits for its PSDONE before the next is issued. A watchdog aborts a step
// whose PSDONE never arrives. A reset command holds the MMCM reset bit
// high for a fixed number of cycles.
//
// Ports
//   phase_control_clk : clock, shared with the generator's PSCLK
//   rst               : asynchronous active-high reset
//   cmd_valid/ready   : command handshake; ready only when idle and out of reset
//   cmd_reset         : 1 = MMCM reset command (cmd_steps ignored)
//   cmd_steps         : signed step count (>0 increment, <0 decrement)
//   ps_ctrl_out       : [0]=PSEN, [1]=PSINCDEC, [7]=MMCM reset, other bits 0
//   ps_ctrl_in        : [0]=PSDONE, other bits ignored
//   busy              : high whenever not idle
//   done              : one-cycle completion pulse
//   error             : sticky PSDONE timeout flag, cleared on next accept
//   position          : signed net accepted steps since last reset
module ritc_phase_shift_controller #(
  parameter int STEP_WIDTH      = 10,
  parameter int POS_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int RST_HOLD_CYCLES = 8
) (
  input  logic                  phase_control_clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_reset,
  input  logic [STEP_WIDTH-1:0] cmd_steps,
  output logic [7:0]            ps_ctrl_out,
  input  logic [7:0]            ps_ctrl_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [POS_WIDTH-1:0]  position
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RESET_HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
  logic                  dir_q, dir_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [POS_WIDTH-1:0]  position_q, position_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  psen_q, psen_d;
  logic                  incdec_q, incdec_d;
  logic                  mmcm_rst_q, mmcm_rst_d;

  logic psdone;
  logic unused_in;

  assign psdone    = ps_ctrl_in[0];
  assign unused_in = ^ps_ctrl_in[7:1];

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    position_d  = position_q;
    error_d     = error_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          error_d = 1'b0;
          if (cmd_reset) begin
            position_d = '0;
            hold_d     = HW'(RST_HOLD_CYCLES);
            state_d    = S_RESET_HOLD;
          end else if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            // Magnitude as unsigned: the most negative value maps to 2^(W-1).
            remaining_d = cmd_steps[STEP_WIDTH-1] ? (~cmd_steps + STEP_WIDTH'(1)) : cmd_steps;
            dir_d       = ~cmd_steps[STEP_WIDTH-1];
            state_d     = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // PSDONE takes priority over a watchdog expiry on the same edge.
        if (psdone) begin
          position_d  = dir_q ? (position_q + POS_WIDTH'(1)) : (position_q - POS_WIDTH'(1));
          remaining_d = remaining_q - STEP_WIDTH'(1);
          if (remaining_q == STEP_WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          error_d     = 1'b1;
          done_d      = 1'b1;
          remaining_d = '0;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_RESET_HOLD: begin
        hold_d = hold_q - HW'(1);
        if (hold_q <= HW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d     = (state_d != S_IDLE);
    psen_d     = (state_d == S_ISSUE);
    incdec_d   = dir_d & ((state_d == S_ISSUE) | (state_d == S_WAIT_DONE));
    mmcm_rst_d = (state_d == S_RESET_HOLD);
  end

  always_ff @(posedge phase_control_clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      timer_q     <= '0;
      hold_q      <= '0;
      position_q  <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      psen_q      <= 1'b0;
      incdec_q    <= 1'b0;
      mmcm_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      position_q  <= position_d;
      error_q     <= error_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      psen_q      <= psen_d;
      incdec_q    <= incdec_d;
      mmcm_rst_q  <= mmcm_rst_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign ps_ctrl_out = {mmcm_rst_q, 5'b00000, incdec_q, psen_q};
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign position    = position_q;

endmodule

// File: tb/tb_ritc_phase_shift_controller.sv
`timescale 1ns/1ps
module tb_ritc_phase_shift_controller;
  localparam int SW = 10;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_reset = 1'b0;
  logic [SW-1:0] cmd_steps = '0;
  logic [7:0]    ps_ctrl_out;
  logic [7:0]    ps_ctrl_in;
  logic          busy, done, error;
  logic [PW-1:0] position;

  ritc_phase_shift_controller #(
    .STEP_WIDTH(SW), .POS_WIDTH(PW), .TIMEOUT_CYCLES(255), .RST_HOLD_CYCLES(8)
  ) dut (
    .phase_control_clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_reset(cmd_reset),
    .cmd_steps(cmd_steps),
    .ps_ctrl_out(ps_ctrl_out),
    .ps_ctrl_in(ps_ctrl_in),
    .busy(busy),
    .done(done),
    .error(error),
    .position(position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Expected outcome of one command, seen when done pulses.
  typedef struct {
    logic [PW-1:0] pos;
    logic          err;
    int            npsen;
    int            nrst;
    logic          dir;
    int            lat;
    bit            from_psen;
  } exp_t;
  exp_t exp_q[$];
  int   model_pos = 0;

  // Generator model: answers PSEN with PSDONE 12 cycles later, except the
  // PSEN whose index within the command equals gen_withhold.
  int         gen_done_at = -1;
  int         gen_idx = 0;
  int         gen_withhold = 0;
  logic       gen_psdone = 1'b0;
  logic       stray = 1'b0;
  logic [6:0] junk = '0;
  assign ps_ctrl_in = {junk, gen_psdone | stray};

  initial forever begin
    @(negedge clk);
    if (cmd_valid && cmd_ready) gen_idx = 0;
    if (ps_ctrl_out[0] === 1'b1) begin
      gen_idx++;
      if (gen_idx != gen_withhold) gen_done_at = cyc + 12;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    gen_psdone = (cyc == gen_done_at);
    junk = 7'($urandom);
  end

  // Monitor: protocol checks every cycle, scoreboard pop on done.
  int   psen_cnt = 0, rst_cnt = 0, accept_cyc = 0, last_psen = 0;
  logic psen_prev = 1'b0, acc_prev = 1'b0, acc_now;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      psen_cnt = 0; rst_cnt = 0; psen_prev = 1'b0; acc_prev = 1'b0;
    end else begin
      if (acc_prev) check("err_clr_on_accept", 32'(error), 0);
      acc_now = cmd_valid && cmd_ready;
      if (acc_now) begin
        accept_cyc = cyc; psen_cnt = 0; rst_cnt = 0;
      end
      if (ps_ctrl_out[0] === 1'b1) begin
        check("psen_single_cycle", 32'(psen_prev), 0);
        check("psen_with_rst", 32'(ps_ctrl_out[7]), 0);
        if (exp_q.size() > 0) begin
          check("psincdec", 32'(ps_ctrl_out[1]), 32'(exp_q[0].dir));
          if (psen_cnt == 0) check("first_psen_lat", 32'(cyc - accept_cyc), 1);
          else check("psen_gap", 32'(cyc - last_psen), 13);
        end
        psen_cnt++;
        last_psen = cyc;
      end
      if (ps_ctrl_out[7] === 1'b1) rst_cnt++;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_position", 32'(position), 32'(e.pos));
          check("done_error", 32'(error), 32'(e.err));
          check("psen_count", 32'(psen_cnt), 32'(e.npsen));
          check("rst_hold_count", 32'(rst_cnt), 32'(e.nrst));
          check("done_busy", 32'(busy), 0);
          check("done_ctrl_out", 32'(ps_ctrl_out), 0);
          check("done_latency", 32'(e.from_psen ? (cyc - last_psen) : (cyc - accept_cyc)), 32'(e.lat));
          $display("cmd done: cycle=%0d pos=0x%0h err=%0b psen=%0d rsthold=%0d", cyc, position, error, psen_cnt, rst_cnt);
        end
      end
      psen_prev = ps_ctrl_out[0];
      acc_prev = acc_now;
    end
  end

  // Reference model of one command, then drive it for a single accept edge.
  task automatic send(input bit r, input int steps, input int withhold, input bit push);
    exp_t e;
    int   n;
    n = (steps < 0) ? -steps : steps;
    e.err = 1'b0; e.npsen = 0; e.nrst = 0; e.dir = (steps > 0); e.from_psen = 1'b0;
    if (r) begin
      model_pos = 0; e.nrst = 8; e.lat = 9;
    end else if (steps == 0) begin
      e.lat = 1;
    end else begin
      e.from_psen = 1'b1;
      if (withhold >= 1 && withhold <= n) begin
        model_pos += ((steps > 0) ? 1 : -1) * (withhold - 1);
        e.err = 1'b1; e.npsen = withhold; e.lat = 256;
      end else begin
        model_pos += steps; e.npsen = n; e.lat = 13;
      end
    end
    e.pos = PW'(model_pos);
    if (push) exp_q.push_back(e);
    gen_withhold = withhold;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_reset = r; cmd_steps = SW'(steps);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_reset = 1'($urandom); cmd_steps = SW'($urandom);
  endtask

  // Wait for done; meanwhile throw cmd_valid pulses at the busy DUT.
  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cmd_valid = busy && ($urandom_range(0, 5) == 0);
        cmd_reset = 1'($urandom);
        cmd_steps = SW'($urandom);
      end
    end
    cmd_valid = 1'b0;
    check("done_seen", 32'(got), 1);
  endtask

  task automatic stray_pulse();
    @(posedge clk); #1; stray = 1'b1;
    @(posedge clk); #1; stray = 1'b0;
  endtask

  initial begin
    int st, wh, n;
    bit r;
    // Power-up reset: async values without any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_ctrl_out", 32'(ps_ctrl_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_position", 32'(position), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("ready_after_rst", 32'(cmd_ready), 1);

    send(0, 3, 0, 1);    wait_done(20000);
    send(0, -5, 0, 1);   wait_done(20000);
    send(0, -512, 0, 1); wait_done(20000);
    send(0, 4, 2, 1);    wait_done(20000);   // timeout on 2nd step
    repeat (20) @(posedge clk);
    stray_pulse();                           // late PSDONE in IDLE
    send(0, 0, 0, 1);    wait_done(20000);   // clears error, position kept

    // rst in the middle of a step command
    send(0, 3, 0, 0);
    repeat (20) @(posedge clk);
    #2 check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("midstep_rst_position", 32'(position), 0);
    check("midstep_rst_ctrl_out", 32'(ps_ctrl_out), 0);
    check("midstep_rst_busy", 32'(busy), 0);
    model_pos = 0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);              // pending PSDONE lands in IDLE
    send(0, 0, 0, 1);    wait_done(20000);

    send(0, 7, 0, 1);    wait_done(20000);
    send(1, 0, 0, 1);    wait_done(20000);   // MMCM reset with position=7
    send(0, 0, 0, 1);    wait_done(20000);
    stray_pulse();
    send(0, 0, 0, 1);    wait_done(20000);

    for (int k = 0; k < 40; k++) begin
      r  = ($urandom_range(0, 7) == 0);
      st = int'($urandom_range(0, 40)) - 20;
      n  = (st < 0) ? -st : st;
      wh = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, n + 2)) : 0;
      send(r, st, wh, 1);
      wait_done(20000);
      if ($urandom_range(0, 3) == 0) stray_pulse();
    end

    // rst in the middle of RESET_HOLD
    send(1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 check("pre_rst_bit7", 32'(ps_ctrl_out[7]), 1);
    rst = 1'b1;
    #1;
    check("hold_rst_ctrl_out", 32'(ps_ctrl_out), 0);
    check("hold_rst_position", 32'(position), 0);
    check("hold_rst_busy", 32'(busy), 0);
    model_pos = 0;
    @(posedge clk); #1 rst = 1'b0;
    #1 check("hold_ready_after_rst", 32'(cmd_ready), 1);
    repeat (10) @(posedge clk);
    send(0, 2, 0, 1);    wait_done(20000);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
